// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module riscv_muldiv_unit #(
    parameter int DW   = 32,
    parameter int CNTW = $clog2(DW) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [2:0]    func3_i,
    input  logic [DW-1:0] op_a_i,
    input  logic [DW-1:0] op_b_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [DW-1:0]     result_q;
    logic [CNTW-1:0]   cnt_q;
    logic [2:0]        func3_q;
    logic              neg_q;
    // hi_q: upper product half / partial remainder
    // lo_q: lower product half (multiplier bits) / dividend shifting into quotient
    logic [DW-1:0]     hi_q;
    logic [DW-1:0]     lo_q;
    logic [DW-1:0]     mcand_q;

    // Start-time decode of the incoming operation
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DW-1:0]     mag_a;
    logic [DW-1:0]     mag_b;
    logic              is_div;
    logic              b_zero;
    logic              div_ovf;
    logic              fast;
    logic [DW-1:0]     fast_res;
    logic              start_neg;

    // Iteration datapath and final sign correction
    logic [DW:0]       mul_sum;
    logic [DW:0]       div_shift;
    logic              div_ge;
    logic [DW-1:0]     hi_d;
    logic [DW-1:0]     lo_d;
    logic [2*DW-1:0]   prod;
    logic [2*DW-1:0]   prod_s;
    logic [DW-1:0]     final_res;

    // Decode operand signedness, magnitudes and the no-iteration special cases
    always_comb begin
        is_div    = func3_i[2];
        a_signed  = is_div ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
        b_signed  = is_div ? ~func3_i[0] : ~func3_i[1];
        a_neg     = a_signed & op_a_i[DW-1];
        b_neg     = b_signed & op_b_i[DW-1];
        mag_a     = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        mag_b     = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        b_zero    = (op_b_i == '0);
        div_ovf   = is_div & ~func3_i[0] & (op_a_i == MIN_NEG) & (op_b_i == '1);
        fast      = is_div & (b_zero | div_ovf);
        // remainder takes the dividend's sign; products and quotients use the xor
        start_neg = (is_div & func3_i[1]) ? a_neg : (a_neg ^ b_neg);
        fast_res  = '0;
        if (b_zero) begin
            fast_res = func3_i[1] ? op_a_i : '1;
        end else begin
            fast_res = func3_i[1] ? '0 : op_a_i;
        end
    end

    // One shift-add or restoring-subtract step, plus the result of the final step
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {DW{1'b0}})};
        div_shift = {hi_q, lo_q[DW-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (func3_q[2]) begin
            hi_d = div_ge ? (div_shift[DW-1:0] - mcand_q) : div_shift[DW-1:0];
            lo_d = {lo_q[DW-2:0], div_ge};
        end else begin
            hi_d = mul_sum[DW:1];
            lo_d = {mul_sum[0], lo_q[DW-1:1]};
        end
        prod   = {hi_d, lo_d};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        if (func3_q[2]) begin
            if (func3_q[1]) begin
                final_res = neg_q ? (~hi_d + 1'b1) : hi_d;
            end else begin
                final_res = neg_q ? (~lo_d + 1'b1) : lo_d;
            end
        end else if (func3_q[1:0] == 2'b00) begin
            final_res = prod_s[DW-1:0];
        end else begin
            final_res = prod_s[2*DW-1:DW];
        end
    end

    // Control FSM with registered busy/done/result and the iteration registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_i) begin
                            func3_q <= func3_i;
                            neg_q   <= start_neg;
                            cnt_q   <= '0;
                            if (fast) begin
                                state_q  <= S_DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                result_q <= fast_res;
                            end else begin
                                state_q <= S_BUSY;
                                busy_q  <= 1'b1;
                                hi_q    <= '0;
                                lo_q    <= is_div ? mag_a : mag_b;
                                mcand_q <= is_div ? mag_b : mag_a;
                            end
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_BUSY: begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (cnt_q == CNTW'(DW - 1)) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= final_res;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
